// File: rtl/sprite_rom_arbiter_pkg.sv
// rtl/sprite_rom_arbiter_pkg.sv - shared types and default widths for the sprite ROM arbiter
//
// Package sprite_arb_pkg: arbiter state enum, in-flight read tag, default
// parameter values used by the interface and the top level.
package sprite_arb_pkg;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_ADDR_W    = 11;
    localparam int DEF_DATA_W    = 4;
    localparam int DEF_ROM_LAT   = 1;
    localparam int DEF_MAX_BURST = 35;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // One entry per ROM read in flight; id is wide enough for 8 requesters.
    typedef struct packed {
        logic       valid;
        logic [2:0] id;
    } tag_t;

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// rtl/sprite_rom_arbiter_if.sv - requester-side bus of the sprite ROM arbiter
//
// Signals (N_REQ requesters share one bundle):
//   req_valid  [N_REQ]          beat pending per requester
//   req_addr   [N_REQ*ADDR_W]   requester i address at [i*ADDR_W +: ADDR_W]
//   req_last   [N_REQ]          beat ends its burst
//   req_ready  [N_REQ]          one-hot or zero; beat taken on valid & ready
//   rsp_valid  [N_REQ]          one-hot response strobe
//   rsp_data   [DATA_W]         returned palette index, shared
// Modports: master = sprite engines side, slave = arbiter side.
interface sprite_rom_arbiter_if
    import sprite_arb_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_data;

    modport master (
        output req_valid, req_addr, req_last,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, req_last,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// rtl/sprite_rom_arbiter_rr_pick.sv - combinational round-robin first-set finder
//
// Ports:
//   req   [N]      request vector
//   ptr   [IDX_W]  highest-priority position (0..N-1)
//   grant [N]      one-hot of first set bit scanning ptr, ptr+1, ... mod N
//   idx   [IDX_W]  index of that bit
//   any            at least one request set
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int j;

    // Scan from the lowest priority upward so the last hit (closest to ptr) wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - round-robin burst arbiter sharing one sprite ROM
//
// Ports:
//   vga_clk      sole clock, posedge
//   reset        synchronous, active-high
//   bus          sprite_rom_arbiter_if.slave (request/response handshake)
//   rom_address  registered address to the shared ROM
//   rom_q        ROM data, valid ROM_LAT cycles after rom_address changes
//   stall_cnt    (SPRITE_ARB_STATS_EN only) saturating stall-cycle count
//   grant_cnt    (SPRITE_ARB_STATS_EN only) saturating 16-bit beat count per requester
// Optional feature macro: SPRITE_ARB_STATS_EN.
module sprite_rom_arbiter
    import sprite_arb_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ROM_LAT   = DEF_ROM_LAT,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                vga_clk,
    input  logic                reset,
    sprite_rom_arbiter_if.slave bus,
    output logic [ADDR_W-1:0]   rom_address,
    input  logic [DATA_W-1:0]   rom_q
`ifdef SPRITE_ARB_STATS_EN
    ,
    output logic [15:0]         stall_cnt,
    output logic [N_REQ*16-1:0] grant_cnt
`endif
);

    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BCNT_W = $clog2(MAX_BURST + 1);

    arb_state_t         state, state_nxt;
    logic [IDX_W-1:0]   owner, owner_nxt;
    logic [IDX_W-1:0]   rr_ptr, rr_nxt;
    logic [BCNT_W-1:0]  beat_cnt, beat_nxt;

    logic [N_REQ-1:0]   pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               pick_last;
    logic               owner_valid;
    logic               owner_last;

    logic [N_REQ-1:0]   ready_c;
    logic               acc;
    logic [IDX_W-1:0]   acc_id;
    logic [ADDR_W-1:0]  sel_addr;
    tag_t               acc_tag;

    tag_t               tag_pipe [0:ROM_LAT];
    tag_t               exit_tag;
    logic [N_REQ-1:0]   rsp_onehot;
    logic [N_REQ-1:0]   rsp_valid_q;
    logic [DATA_W-1:0]  rsp_data_q;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] p);
        if (int'(p) >= N_REQ - 1) begin
            return '0;
        end
        return p + IDX_W'(1);
    endfunction

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign pick_last   = bus.req_last[pick_idx];
    assign owner_valid = bus.req_valid[owner];
    assign owner_last  = bus.req_last[owner];

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
        beat_nxt  = beat_cnt;
        ready_c   = '0;
        acc       = 1'b0;
        acc_id    = owner;
        if (!reset) begin
            case (state)
                IDLE: begin
                    // IDLE grants combinationally so bursts from different
                    // requesters follow each other without a bubble.
                    if (pick_any) begin
                        ready_c = pick_grant;
                        acc     = 1'b1;
                        acc_id  = pick_idx;
                        if (pick_last || MAX_BURST == 1) begin
                            rr_nxt = wrap_inc(pick_idx);
                        end else begin
                            state_nxt = BURST;
                            owner_nxt = pick_idx;
                            beat_nxt  = BCNT_W'(1);
                        end
                    end
                end
                BURST: begin
                    if (owner_valid) begin
                        ready_c[owner] = 1'b1;
                        acc            = 1'b1;
                        beat_nxt       = beat_cnt + BCNT_W'(1);
                        if (owner_last || (int'(beat_cnt) + 1 == MAX_BURST)) begin
                            state_nxt = IDLE;
                            rr_nxt    = wrap_inc(owner);
                        end
                    end else begin
                        // Owner went quiet mid-burst: give the ROM away this edge.
                        state_nxt = IDLE;
                        rr_nxt    = wrap_inc(owner);
                        beat_nxt  = '0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (acc_id == IDX_W'(i)) begin
                sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign acc_tag = {acc, 3'(acc_id)};

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= '0;
            rr_ptr      <= '0;
            beat_cnt    <= '0;
            rom_address <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_nxt;
            beat_cnt <= beat_nxt;
            if (acc) begin
                rom_address <= sel_addr;
            end
        end
    end

    // Stage 0 rides alongside rom_address; stage ROM_LAT lines up with rom_q.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            for (int k = 0; k <= ROM_LAT; k++) begin
                tag_pipe[k] <= '0;
            end
        end else begin
            tag_pipe[0] <= acc_tag;
            for (int k = 1; k <= ROM_LAT; k++) begin
                tag_pipe[k] <= tag_pipe[k-1];
            end
        end
    end

    assign exit_tag = tag_pipe[ROM_LAT];

    always_comb begin
        rsp_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_onehot[i] = exit_tag.valid && (exit_tag.id == 3'(i));
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_onehot;
            if (exit_tag.valid) begin
                rsp_data_q <= rom_q;
            end
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

`ifdef SPRITE_ARB_STATS_EN
    logic [15:0] stall_q;
    logic [15:0] grant_q [N_REQ];

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            stall_q <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                grant_q[i] <= '0;
            end
        end else begin
            if ((|bus.req_valid) && !acc && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (acc && (acc_id == IDX_W'(i)) && (grant_q[i] != 16'hFFFF)) begin
                    grant_q[i] <= grant_q[i] + 16'd1;
                end
            end
        end
    end

    assign stall_cnt = stall_q;

    for (genvar g = 0; g < N_REQ; g++) begin : g_grant
        assign grant_cnt[g*16 +: 16] = grant_q[g];
    end
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb/tb_sprite_rom_arbiter.sv - self-checking bench for sprite_rom_arbiter
module tb_sprite_rom_arbiter;

    logic        vga_clk = 1'b0;
    logic        reset   = 1'b1;
    logic [10:0] rom_address;
    logic [3:0]  rom_q   = 4'h0;
    int          checks  = 0;
    int          errors  = 0;

`ifdef SPRITE_ARB_STATS_EN
    logic [15:0] stall_cnt;
    logic [63:0] grant_cnt;
`endif

    sprite_rom_arbiter_if #(.N_REQ(4), .ADDR_W(11), .DATA_W(4)) bus ();

    sprite_rom_arbiter #(
        .N_REQ     (4),
        .ADDR_W    (11),
        .DATA_W    (4),
        .ROM_LAT   (1),
        .MAX_BURST (35)
    ) dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .bus         (bus),
        .rom_address (rom_address),
        .rom_q       (rom_q)
`ifdef SPRITE_ARB_STATS_EN
        ,
        .stall_cnt   (stall_cnt),
        .grant_cnt   (grant_cnt)
`endif
    );

    always #5 vga_clk = ~vga_clk;

    // ROM model: one-cycle registered read, data = low nibble of address ^ 0xA.
    always @(posedge vga_clk) rom_q <= rom_address[3:0] ^ 4'hA;

    typedef struct {
        logic [3:0]  v;
        logic [3:0]  l;
        logic [10:0] base;
        logic [3:0]  rdy;
        logic [3:0]  rv;
        logic [3:0]  rd;
        logic [10:0] ad;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l,
                         input logic [10:0] a0, input logic [10:0] a1,
                         input logic [10:0] a2, input logic [10:0] a3);
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_addr  = {a3, a2, a1, a0};
    endtask

    task automatic step(input logic [3:0] v, input logic [3:0] l,
                        input logic [10:0] a0, input logic [10:0] a1,
                        input logic [10:0] a2, input logic [10:0] a3);
        @(negedge vga_clk);
        drive(v, l, a0, a1, a2, a3);
        #1;
    endtask

    task automatic reset_dut();
        @(negedge vga_clk);
        reset = 1'b1;
        drive(4'b0000, 4'b0000, 11'd0, 11'd0, 11'd0, 11'd0);
        @(negedge vga_clk);
        reset = 1'b0;
    endtask

    initial begin
        // v, l, base, ready, rsp_valid, rsp_data, rom_address (requester i addr = base+i)
        tbl[0]  = '{4'b0001, 4'b0001, 11'd100, 4'b0001, 4'b0000, 4'h0, 11'd0};
        tbl[1]  = '{4'b0000, 4'b0000, 11'd0,   4'b0000, 4'b0000, 4'h0, 11'd100};
        tbl[2]  = '{4'b0000, 4'b0000, 11'd0,   4'b0000, 4'b0000, 4'h0, 11'd100};
        tbl[3]  = '{4'b0110, 4'b0110, 11'd200, 4'b0010, 4'b0001, 4'hE, 11'd100};
        tbl[4]  = '{4'b0100, 4'b0100, 11'd200, 4'b0100, 4'b0000, 4'h0, 11'd201};
        tbl[5]  = '{4'b0000, 4'b0000, 11'd0,   4'b0000, 4'b0000, 4'h0, 11'd202};
        tbl[6]  = '{4'b0000, 4'b0000, 11'd0,   4'b0000, 4'b0010, 4'h3, 11'd202};
        tbl[7]  = '{4'b0000, 4'b0000, 11'd0,   4'b0000, 4'b0100, 4'h0, 11'd202};
        tbl[8]  = '{4'b1001, 4'b1001, 11'd0,   4'b1000, 4'b0000, 4'h0, 11'd202};
        tbl[9]  = '{4'b1001, 4'b1001, 11'd0,   4'b0001, 4'b0000, 4'h0, 11'd3};
        tbl[10] = '{4'b0000, 4'b0000, 11'd0,   4'b0000, 4'b0000, 4'h0, 11'd0};
        tbl[11] = '{4'b0000, 4'b0000, 11'd0,   4'b0000, 4'b1000, 4'h9, 11'd0};
        tbl[12] = '{4'b0000, 4'b0000, 11'd0,   4'b0000, 4'b0001, 4'hA, 11'd0};
        tbl[13] = '{4'b0000, 4'b0000, 11'd0,   4'b0000, 4'b0000, 4'h0, 11'd0};

        // Reset: ready held low even with every requester valid.
        drive(4'b1111, 4'b1111, 11'd7, 11'd7, 11'd7, 11'd7);
        #1;
        chk("reset_ready", 32'(bus.req_ready), 32'h0);
        @(negedge vga_clk);
        @(negedge vga_clk);
        reset = 1'b0;
        drive(4'b0000, 4'b0000, 11'd0, 11'd0, 11'd0, 11'd0);
        #1;
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("reset_rsp_data", 32'(bus.rsp_data), 32'h0);

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].v, tbl[i].l, tbl[i].base, tbl[i].base + 11'd1,
                 tbl[i].base + 11'd2, tbl[i].base + 11'd3);
            chk($sformatf("vec%0d_ready", i), 32'(bus.req_ready), 32'(tbl[i].rdy));
            chk($sformatf("vec%0d_rsp_valid", i), 32'(bus.rsp_valid), 32'(tbl[i].rv));
            chk($sformatf("vec%0d_rom_address", i), 32'(rom_address), 32'(tbl[i].ad));
            if (tbl[i].rv != 4'b0000) begin
                chk($sformatf("vec%0d_rsp_data", i), 32'(bus.rsp_data), 32'(tbl[i].rd));
            end
        end

        // Full 35-beat burst from requester 0 while 3 waits; 3 follows with no bubble.
        reset_dut();
        for (int k = 0; k < 35; k++) begin
            step(4'b1001, {1'b1, 2'b00, (k == 34)}, 11'(k), 11'd0, 11'd0, 11'd500);
            chk($sformatf("burst35_beat%0d", k), 32'(bus.req_ready), 32'b0001);
        end
        step(4'b1000, 4'b1000, 11'd0, 11'd0, 11'd0, 11'd500);
        chk("burst35_next_grant", 32'(bus.req_ready), 32'b1000);

        // Requester 2 never sets last: forced release at 35, then rotation, then abandon.
        reset_dut();
        for (int k = 0; k < 35; k++) begin
            step(4'b1100, 4'b1000, 11'd0, 11'd0, 11'(k), 11'd600);
            chk($sformatf("force_beat%0d", k), 32'(bus.req_ready), 32'b0100);
        end
        step(4'b1100, 4'b1000, 11'd0, 11'd0, 11'd35, 11'd600);
        chk("force_rotate_to3", 32'(bus.req_ready), 32'b1000);
        for (int k = 0; k < 5; k++) begin
            step(4'b0100, 4'b0000, 11'd0, 11'd0, 11'(36 + k), 11'd0);
            chk($sformatf("regrant2_beat%0d", k), 32'(bus.req_ready), 32'b0100);
        end
        step(4'b1001, 4'b1001, 11'd10, 11'd0, 11'd0, 11'd13);
        chk("abandon_ready", 32'(bus.req_ready), 32'b0000);
        step(4'b1001, 4'b1001, 11'd10, 11'd0, 11'd0, 11'd13);
        chk("abandon_ptr3", 32'(bus.req_ready), 32'b1000);
        step(4'b1001, 4'b1001, 11'd10, 11'd0, 11'd0, 11'd13);
        chk("abandon_wrap0", 32'(bus.req_ready), 32'b0001);

        // Reset with one beat in flight: its response must never appear.
        reset_dut();
        step(4'b0001, 4'b0001, 11'd55, 11'd0, 11'd0, 11'd0);
        chk("flight_accept", 32'(bus.req_ready), 32'b0001);
        @(negedge vga_clk);
        reset = 1'b1;
        #1;
        chk("flight_reset_ready", 32'(bus.req_ready), 32'h0);
        @(negedge vga_clk);
        reset = 1'b0;
        drive(4'b0000, 4'b0000, 11'd0, 11'd0, 11'd0, 11'd0);
        #1;
        chk("flight_rom_address", 32'(rom_address), 32'h0);
        chk("flight_rsp_data", 32'(bus.rsp_data), 32'h0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("flight_no_rsp%0d", k), 32'(bus.rsp_valid), 32'h0);
            @(negedge vga_clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Round-robin burst arbiter that shares one single-port sprite/image ROM among several sprite drawing engines (step indicators, playhead, labels) in the beat-sequencer VGA path. Each requester issues ROM addresses with a valid/ready handshake, optionally grouped into bursts (one sprite row). The arbiter drives the shared ROM address, tracks in-flight reads through the fixed ROM latency, and returns each palette index to the requester that issued it.

## Interface
- N_REQ, 4: number of requesters (2..8)
- ADDR_W, 11: ROM address width
- DATA_W, 4: ROM word width (palette index)
- ROM_LAT, 1: ROM read latency in vga_clk cycles (1..3)
- MAX_BURST, 35: maximum beats per grant before forced rotation
- vga_clk  in  1  sole clock; all logic on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  N_REQ  request pending per requester
- req_addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_last  in  N_REQ  beat is the last of its burst
- req_ready  out  N_REQ  one-hot or zero; beat accepted when valid&ready
- rom_address  out  ADDR_W  registered address to shared ROM
- rom_q  in  DATA_W  ROM data, valid ROM_LAT cycles after rom_address changes
- rsp_valid  out  N_REQ  one-hot response strobe
- rsp_data  out  DATA_W  returned word, shared by all requesters

## Operation
- States: IDLE, BURST. Registers: state, owner, rr_ptr, beat_cnt.
- IDLE: winner = first i with req_valid[i] scanning rr_ptr, rr_ptr+1, ... mod N_REQ; req_ready[winner]=1 combinationally, accepting that beat (beat 1). If that beat has req_last or MAX_BURST==1 -> stay IDLE, rr_ptr<=winner+1; else -> BURST, owner<=winner, beat_cnt<=1. No valid -> stay IDLE, all ready 0.
- BURST: req_ready[owner]=req_valid[owner]; others 0. On accepted beat: beat_cnt++; if req_last or beat_cnt+1==MAX_BURST -> IDLE, rr_ptr<=owner+1. If req_valid[owner] low -> IDLE same edge, rr_ptr<=owner+1 (burst abandoned; no partial state kept).
- Accept at edge t: rom_address<=addr; tag {valid, id} enters ROM_LAT-deep shift register.
- Tag exits aligned with rom_q; rsp_valid[id]<=1, rsp_data<=rom_q one edge later.
- rom_address holds last value when nothing is accepted.
- Forced rotation at MAX_BURST: requester keeps valid high and re-arbitrates in IDLE like any other.

## Timing
- Reset: state=IDLE, rr_ptr=0, owner=0, beat_cnt=0, tag pipe cleared, rom_address=0, rsp_valid=0, rsp_data=0; req_ready=0 during reset cycle.
- Accept-to-response latency: ROM_LAT+1 edges (default: accept edge t, rsp_valid high in cycle after edge t+2).
- Throughput: one beat per cycle; back-to-back bursts from different requesters have no bubble (IDLE grants combinationally).
- Ready depends combinationally on req_valid; req_valid must not depend on req_ready.
- Reset mid-burst: in-flight tags dropped; no rsp_valid for them.
- rr_ptr wraps N_REQ-1 -> 0.

## Configuration
- SPRITE_ARB_STATS_EN defined: adds output stall_cnt (16 bits, saturating) counting cycles where any req_valid is high with no beat accepted, and grant_cnt (N_REQ*16, saturating) counting accepted beats per requester; both reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Package sprite_arb_pkg: state enum (IDLE, BURST), tag struct {logic valid; logic [2:0] id;}, default widths.
- Sub-module rr_pick: combinational round-robin first-set finder (req vector, pointer -> one-hot + index, any).

## Test plan
- Single requester 0, address 100, req_last=1 -> req_ready[0] same cycle; rom_address=100 next edge; rsp_valid[0] with ROM model data 2 edges after accept.
- Requesters 1 and 2 both single-beat, rr_ptr=0 -> 1 granted first, 2 next cycle, rr_ptr=3 afterwards; responses in that order.
- Requester 0 burst of 35 addresses (last on 35th), requester 3 waiting -> 0 holds 35 consecutive cycles, 3 granted on cycle 36 with no bubble.
- Requester 2 burst of 50 with no req_last, MAX_BURST=35 -> releases after 35 beats; re-granted only after other waiting requesters.
- Owner drops valid after 5 beats -> state IDLE, rr_ptr=owner+1, other requester granted next cycle.
- Reset asserted with 1 beat in flight -> no rsp_valid afterward, all outputs zero.
